// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared state encoding and step-shifter sizing for shift_sequencer
package shift_seq_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int STEP_MAX = 3;
    localparam int STEP_W = 2;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational DATA_W-bit logical left shift by 0-3 positions
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [STEP_W-1:0] sel,
    output logic [DATA_W-1:0] y
);
    assign y = a << sel;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle left shifter issuing 0-3 steps through shift_step.
// Optional overflow flag output built when SHIFT_SEQ_OVF_EN is defined.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int AMT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef SHIFT_SEQ_OVF_EN
    output logic              out_ovf,
`endif
    output logic              busy
);
    state_t state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d, shifted;
    logic [AMT_W-1:0] rem_q, rem_d, rem_next;
    logic [STEP_W-1:0] step;

    assign step = (rem_q > AMT_W'(STEP_MAX)) ? STEP_W'(STEP_MAX) : rem_q[STEP_W-1:0];
    assign rem_next = rem_q - AMT_W'(step);

    shift_step #(.DATA_W(DATA_W)) u_step (.a(data_q), .sel(step), .y(shifted));

    always_comb begin
        state_d = state_q;
        data_d = data_q;
        rem_d = rem_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                data_d = in_data;
                rem_d = in_amt;
                state_d = SHIFT;
            end
            SHIFT: begin
                data_d = shifted;
                rem_d = rem_next;
                state_d = (rem_next == '0) ? DONE : SHIFT;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q <= '0;
            rem_q <= '0;
        end else begin
            state_q <= state_d;
            data_q <= data_d;
            rem_q <= rem_d;
        end
    end

`ifdef SHIFT_SEQ_OVF_EN
    logic ovf_q, ovf_d;
    // bits leaving the MSB this step are the top `step` bits of data_q
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == IDLE && in_valid)
            ovf_d = 1'b0;
        else if (state_q == SHIFT)
            ovf_d = ovf_q | (|(data_q & ~({DATA_W{1'b1}} >> step)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_d;
    end

    assign out_ovf = ovf_q & (state_q == DONE);
`endif

    assign in_ready = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy = (state_q != IDLE);
    assign out_data = data_q;
endmodule
